// File: rtl/mux_parity_pkg.sv
// Shared types and elaboration helpers for the mux-built parity pipeline.
package mux_parity_pkg;

    typedef enum logic {
        PAR_WORD   = 1'b0,
        PAR_PACKET = 1'b1
    } parity_mode_e;

    // Number of XOR-tree levels needed to reduce a word of the given width.
    function automatic int depth(input int width);
        return (width > 1) ? $clog2(width) : 0;
    endfunction

    function automatic int stages(input int width, input int lps);
        return (depth(width) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/mux.sv
// Team 2:1 multiplexer cell; every gate in the parity engine is built from it.
module mux (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/xor2_mux.sv
// Two-input XOR made of two mux cells: one inverts b, the other selects b or ~b on a.
module xor2_mux (
    input  logic a,
    input  logic b,
    output logic y
);

    logic b_n;

    mux u_inv (.d0(1'b1), .d1(1'b0), .sel(b), .y(b_n));
    mux u_sel (.d0(b),    .d1(b_n),  .sel(a), .y(y));

endmodule

// File: rtl/mux_parity_pipe.sv
// Pipelined parity reducer: balanced mux-XOR tree with per-word or per-packet accumulation.
module mux_parity_pipe
    import mux_parity_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int LEVELS_PER_STAGE = 1,
    parameter int COUNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up_valid,
    input  logic [WIDTH-1:0]   up_data,
    input  logic               up_last,
    input  logic               up_mode,
    input  logic               up_odd,
    output logic               down_valid,
    output logic               down_parity,
    output logic [COUNT_W-1:0] down_count
);

    localparam int D      = depth(WIDTH);
    localparam int S      = stages(WIDTH, LEVELS_PER_STAGE);
    localparam int NPAD   = 1 << D;
    localparam int TREE_W = 2 * NPAD - 1;

    // All tree levels packed back to back: level l starts at 2*NPAD - 2*(NPAD>>l).
    // Sideband per level is {valid, mode, odd, last}.
    logic [TREE_W-1:0]  tree;
    logic [4*(D+1)-1:0] side;

    genvar gi, gj;

    generate
        for (gi = 0; gi < NPAD; gi++) begin : gen_leaf
            if (gi < WIDTH) begin : gen_data
                assign tree[gi] = up_data[gi];
            end else begin : gen_pad
                assign tree[gi] = 1'b0;
            end
        end
    endgenerate

    assign side[3:0] = {up_valid, up_mode, up_odd, up_last};

    generate
        for (gi = 0; gi < D; gi++) begin : gen_lvl
            localparam int N_OUT   = NPAD >> (gi + 1);
            localparam int IN_OFF  = 2 * NPAD - 2 * (NPAD >> gi);
            localparam int OUT_OFF = 2 * NPAD - (NPAD >> gi);
            localparam int STG     = gi / LEVELS_PER_STAGE;
            localparam int LAST    = (STG == S - 1) ? D - 1 : (STG + 1) * LEVELS_PER_STAGE - 1;

            logic [N_OUT-1:0] res;

            for (gj = 0; gj < N_OUT; gj++) begin : gen_node
                xor2_mux u_xor (
                    .a (tree[IN_OFF + 2*gj]),
                    .b (tree[IN_OFF + 2*gj + 1]),
                    .y (res[gj])
                );
            end

            if (gi == LAST) begin : gen_reg
                logic [N_OUT-1:0] res_reg;
                logic [3:0]       side_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        res_reg  <= '0;
                        side_reg <= '0;
                    end else begin
                        res_reg  <= res;
                        side_reg <= side[4*gi +: 4];
                    end
                end

                assign tree[OUT_OFF +: N_OUT]  = res_reg;
                assign side[4*(gi+1) +: 4]     = side_reg;
            end else begin : gen_comb
                assign tree[OUT_OFF +: N_OUT]  = res;
                assign side[4*(gi+1) +: 4]     = side[4*gi +: 4];
            end
        end
    endgenerate

    logic               p, f_valid, f_mode, f_odd, f_last;
    logic               acc_reg, cnt_dummy;
    logic [COUNT_W-1:0] cnt_reg, cnt_next;
    logic               par_word, acc_next, par_pkt;
    logic               down_valid_reg, down_parity_reg;
    logic [COUNT_W-1:0] down_count_reg;

    assign p = tree[TREE_W-1];
    assign {f_valid, f_mode, f_odd, f_last} = side[4*D +: 4];
    assign cnt_dummy = 1'b0;

    xor2_mux u_word (.a(p),        .b(f_odd), .y(par_word));
    xor2_mux u_acc  (.a(acc_reg),  .b(p),     .y(acc_next));
    xor2_mux u_pkt  (.a(acc_next), .b(f_odd), .y(par_pkt));

    // Saturating word count; parity keeps accumulating past saturation.
    assign cnt_next = (cnt_reg == {COUNT_W{1'b1}}) ? cnt_reg : cnt_reg + COUNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg         <= 1'b0;
            cnt_reg         <= '0;
            down_valid_reg  <= 1'b0;
            down_parity_reg <= 1'b0;
            down_count_reg  <= '0;
        end else begin
            down_valid_reg <= 1'b0;
            if (f_valid) begin
                if (parity_mode_e'(f_mode) == PAR_WORD) begin
                    down_valid_reg  <= 1'b1;
                    down_parity_reg <= par_word;
                    down_count_reg  <= COUNT_W'(1);
                end else if (f_last) begin
                    down_valid_reg  <= 1'b1;
                    down_parity_reg <= par_pkt;
                    down_count_reg  <= cnt_next;
                    acc_reg         <= cnt_dummy;
                    cnt_reg         <= '0;
                end else begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_next;
                end
            end
        end
    end

    assign down_valid  = down_valid_reg;
    assign down_parity = down_parity_reg;
    assign down_count  = down_count_reg;

endmodule

// File: tb/tb_mux_parity_pipe.sv
// Drives four parameterisations of mux_parity_pipe and checks them cycle by cycle against a queue-free parity model.
module tb_mux_parity_pipe;

    logic       clk = 1'b0;
    logic       rst, up_valid, up_last, up_mode, up_odd;
    logic [7:0] up_data;

    always #5 clk = ~clk;

    logic       dv0, dv1, dv2, dv3;
    logic       dp0, dp1, dp2, dp3;
    logic [7:0] dc0, dc1, dc2;
    logic [1:0] dc3;

    mux_parity_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(1), .COUNT_W(8)) u0 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_last(up_last),
        .up_mode(up_mode), .up_odd(up_odd), .down_valid(dv0), .down_parity(dp0), .down_count(dc0));
    mux_parity_pipe #(.WIDTH(5), .LEVELS_PER_STAGE(2), .COUNT_W(8)) u1 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data[4:0]), .up_last(up_last),
        .up_mode(up_mode), .up_odd(up_odd), .down_valid(dv1), .down_parity(dp1), .down_count(dc1));
    mux_parity_pipe #(.WIDTH(1), .LEVELS_PER_STAGE(1), .COUNT_W(8)) u2 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data[0:0]), .up_last(up_last),
        .up_mode(up_mode), .up_odd(up_odd), .down_valid(dv2), .down_parity(dp2), .down_count(dc2));
    mux_parity_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(1), .COUNT_W(2)) u3 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_last(up_last),
        .up_mode(up_mode), .up_odd(up_odd), .down_valid(dv3), .down_parity(dp3), .down_count(dc3));

    // Latencies S+1 worked out by hand: W8/L1 -> 4, W5/L2 -> 3, W1 -> 1, W8/L1 -> 4.
    int         lat  [4] = '{4, 3, 1, 4};
    logic [7:0] mask [4] = '{8'hFF, 8'h1F, 8'h01, 8'hFF};
    int         cmax [4] = '{255, 255, 255, 3};

    bit  sv [4][8];
    bit  sp [4][8];
    int  sc [4][8];
    bit  hp [4];
    int  hc [4];
    bit  macc [4];
    int  mcnt [4];
    int  cyc = 0;
    int  total = 0;
    int  passed = 0;

    task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s dut%0d cyc%0d got %0h want %0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d,
                        input bit m, input bit o, input bit l);
        bit res_p;
        int res_c;
        bit emit;
        int s;
        rst = r; up_valid = v; up_data = d; up_mode = m; up_odd = o; up_last = l;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                for (int j = 0; j < 8; j++) sv[k][j] = 1'b0;
                hp[k] = 1'b0; hc[k] = 0; macc[k] = 1'b0; mcnt[k] = 0;
            end else if (v) begin
                bit pw;
                pw = 1'($countones(d & mask[k]) & 1);
                emit = 1'b1;
                if (!m) begin
                    res_p = pw ^ o; res_c = 1;
                end else begin
                    macc[k] = macc[k] ^ pw;
                    mcnt[k] = (mcnt[k] < cmax[k]) ? mcnt[k] + 1 : mcnt[k];
                    res_p = macc[k] ^ o; res_c = mcnt[k];
                    emit = l;
                    if (l) begin macc[k] = 1'b0; mcnt[k] = 0; end
                end
                if (emit) begin
                    s = (cyc + lat[k]) % 8;
                    sv[k][s] = 1'b1; sp[k][s] = res_p; sc[k][s] = res_c;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 4; k++) begin
            bit ev;
            logic [7:0] ov, op, oc;
            s = cyc % 8;
            ev = sv[k][s];
            if (ev) begin hp[k] = sp[k][s]; hc[k] = sc[k][s]; end
            sv[k][s] = 1'b0;
            case (k)
                0: begin ov = {7'd0, dv0}; op = {7'd0, dp0}; oc = dc0; end
                1: begin ov = {7'd0, dv1}; op = {7'd0, dp1}; oc = dc1; end
                2: begin ov = {7'd0, dv2}; op = {7'd0, dp2}; oc = dc2; end
                default: begin ov = {7'd0, dv3}; op = {7'd0, dp3}; oc = {6'd0, dc3}; end
            endcase
            check("valid",  k, ov, {7'd0, ev});
            check("parity", k, op, {7'd0, hp[k]});
            check("count",  k, oc, 8'(hc[k]));
        end
        $display("cyc%0d rst=%0b v=%0b d=%02h m=%0b o=%0b l=%0b | dv=%0b%0b%0b%0b dp=%0b%0b%0b%0b",
                 cyc, r, v, d, m, o, l, dv0, dv1, dv2, dv3, dp0, dp1, dp2, dp3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) sv[k][j] = 1'b0;
            hp[k] = 1'b0; hc[k] = 0; macc[k] = 1'b0; mcnt[k] = 0;
        end
        rst = 1'b1; up_valid = 1'b0; up_data = 8'h00; up_mode = 1'b0; up_odd = 1'b0; up_last = 1'b0;
        #1;
        step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(1);
        // word mode
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        idle(5);
        step(1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0);
        idle(5);
        // streaming
        step(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        idle(5);
        // packet mode
        step(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
        idle(5);
        step(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        idle(5);
        // reset mid-packet
        step(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        idle(5);
        // odd width pattern
        step(1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 1'b0);
        idle(5);
        // saturation on the COUNT_W=2 instance
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, (i == 4));
        idle(5);
        // mixed modes back to back
        step(1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        idle(5);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
        end
        idle(6);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_parity_pipe.md
Name: mux_parity_pipe

Overview:
- Parametrised parity engine built only from the team's 2:1 `mux` cell, a flop per pipeline stage, and 0/1 constants.
- Reduces a WIDTH-bit word to one parity bit through a balanced tree of mux-based XOR2 cells.
- Pipeline registers are inserted every LEVELS_PER_STAGE tree levels.
- Supports per-word mode and packet mode, where parity accumulates across words until `up_last`. It is the first sequential, generalised member of the gate-from-mux family.

Parameters:
- WIDTH, 8, input word width, >=1.
- LEVELS_PER_STAGE, 1, XOR-tree levels between pipeline registers, >=1.
- COUNT_W, 8, width of the packet word counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- up_valid  input  1  input word present this cycle.
- up_data  input  WIDTH  word to reduce.
- up_last  input  1  final word of a packet; ignored in word mode.
- up_mode  input  1  0 = word mode, 1 = packet mode; sampled with up_valid.
- up_odd  input  1  1 = invert the result (odd parity); sampled with up_valid.
- down_valid  output  1  result valid, single-cycle pulse.
- down_parity  output  1  parity result.
- down_count  output  COUNT_W  words contributing to the result.

Behaviour:
- Definitions:
  - D = $clog2(WIDTH); D = 0 when WIDTH = 1.
  - S = ceil(D / LEVELS_PER_STAGE).
  - Latency L = S + 1 cycles from an accepted up_valid to down_valid.
- Tree:
  - Leaves are padded to 2^D with 1'b0.
  - Each node is an xor2 built from two mux instances with constants; no `^` operator anywhere in the block.
- Pipeline:
  - There is no backpressure; one word is accepted per cycle when up_valid=1.
  - up_mode, up_odd and up_last travel with the data through every stage.
  - The mode therefore applies per word; mixing modes back-to-back is legal.
- Final stage, with p = tree result of the word arriving at the final stage:
  - Word mode: down_valid=1, down_parity=p^odd, down_count=1. acc and cnt are untouched.
  - Packet mode, not last: acc<=acc^p, cnt<=cnt+1 (saturating at 2^COUNT_W-1); down_valid=0.
  - Packet mode, last: down_valid=1, down_parity=acc^p^odd, down_count=sat(cnt+1); acc<=0, cnt<=0.
  - A one-word packet (last on the first word) yields p^odd, count 1.
- Outputs are registered. down_parity and down_count hold their last value while down_valid=0.
- Reset:
  - All stage valids, acc, cnt, down_valid, down_parity and down_count are cleared to 0.
  - Reset mid-operation drops every in-flight word and any partial packet.
  - No down_valid occurs in the cycle after rst deasserts.
  - up_valid during rst is ignored.
- Counter saturation: cnt stops at max. Parity accumulation continues normally.

Decomposition:
- Package `mux_parity_pkg`:
  - Typedef `parity_mode_e` {PAR_WORD=1'b0, PAR_PACKET=1'b1}.
  - Function `stages(width, lps)` returning S.
- Sub-module `xor2_mux`: two `mux` instances forming one XOR2 cell.
- The tree is generated level by level in mux_parity_pipe.

Test Plan:
- Reset: hold rst=1 for 2 cycles with up_valid=1 -> down_valid=0, down_parity=0, down_count=0 throughout and on the first cycle after release.
- Word mode, WIDTH=8, LPS=1 (L=4):
  - 8'hA5 at cycle 0 -> down_valid at cycle 4, parity 0, count 1.
  - 8'h07 with up_odd=1 -> parity 0.
- Streaming: 8'h01, 8'h03, 8'hFF, 8'h80 on consecutive cycles in word mode -> four consecutive down_valid pulses at cycles 4..7, parities 1,0,0,1.
- Packet mode: 8'h01, 8'h03, 8'h80(last) on cycles 0..2 -> a single down_valid at cycle 6, parity 0, count 3. Then 8'h01(last) -> parity 1, count 1.
- Reset mid-packet: 8'h01, 8'h01, rst pulse, then 8'h01(last) -> parity 1, count 1; no output for the dropped words.
- Odd width and deeper stages: WIDTH=5, LPS=2 (D=3, S=2, L=3):
  - 5'b10110 -> parity 1 after 3 cycles.
  - WIDTH=1: 1'b1 -> parity 1 after 1 cycle.
- Saturation: COUNT_W=2 with a 5-word packet of 8'h01 -> count 3, parity 1.
